branch_hazard_sequencer: RTL and testbench

//  Sequences pipeline stalls/flushes for branch resolution and load-use hazards.

---
 rtl/branch_hazard_sequencer_pkg.sv | 13 +
 rtl/branch_hazard_sequencer_load_use_detect.sv | 20 ++
 rtl/branch_hazard_sequencer.sv | 129 ++++++++++++
 tb/tb_branch_hazard_sequencer.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/branch_hazard_sequencer_pkg.sv
// Shared definitions for the branch/load-use hazard sequencer: FSM state
// encoding and the default register-address width.
package branch_hazard_sequencer_pkg;

  localparam int unsigned REG_AW_DEF = 5;

  // Two-bit encoding leaves two spare codes; any spare decode returns to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_BR_WAIT = 2'b01
  } hz_state_t;

endpackage

// File: rtl/branch_hazard_sequencer_load_use_detect.sv
// Combinational load-use comparator: a load in EX writing a non-zero register
// that the instruction in ID reads. Shared with the forwarding unit.
module load_use_detect
  import branch_hazard_sequencer_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEF
) (
  input  logic              memReadEX,
  input  logic [REG_AW-1:0] rtEX,
  input  logic [REG_AW-1:0] rsID,
  input  logic [REG_AW-1:0] rtID,
  output logic              loadUse
);

  // Register 0 is hardwired, so a load targeting it never creates a hazard.
  always_comb begin
    loadUse = memReadEX && (rtEX != '0) && ((rtEX == rsID) || (rtEX == rtID));
  end

endmodule

// File: rtl/branch_hazard_sequencer.sv
// Branch / load-use hazard sequencer. Stalls for load-use hazards and holds the
// front end while a beq/bne waits for the EX comparator, then steers the PC and
// squashes the wrong-path fetch. A branch that never resolves times out after
// BR_MAX_WAIT cycles and is treated as not-taken.
// Optional feature macro: HAZARD_PERF_EN (adds saturating stall counters).
module branch_hazard_sequencer
  import branch_hazard_sequencer_pkg::*;
#(
  parameter int unsigned REG_AW      = REG_AW_DEF,
  parameter int unsigned BR_MAX_WAIT = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              beqID,
  input  logic              bneID,
  input  logic              branchResolve,
  input  logic              branchTaken,
  input  logic              memReadEX,
  input  logic [REG_AW-1:0] rtEX,
  input  logic [REG_AW-1:0] rsID,
  input  logic [REG_AW-1:0] rtID,
  output logic              PChold,
  output logic              IFIDhold,
  output logic              IFIDflush,
  output logic              IDEXbubble,
  output logic              pcSrcBranch,
`ifdef HAZARD_PERF_EN
  output logic [CNT_W-1:0]  loadStallCnt,
  output logic [CNT_W-1:0]  branchStallCnt,
`endif
  output logic              brTimeout
);

  localparam int unsigned     CW       = $clog2(BR_MAX_WAIT + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(BR_MAX_WAIT - 1);

  hz_state_t     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          loadUse;

  load_use_detect #(.REG_AW(REG_AW)) u_lud (
    .memReadEX (memReadEX),
    .rtEX      (rtEX),
    .rsID      (rsID),
    .rtID      (rtID),
    .loadUse   (loadUse)
  );

  // State and wait-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state and output decode; everything is forced low during reset.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    PChold      = 1'b0;
    IFIDhold    = 1'b0;
    IFIDflush   = 1'b0;
    IDEXbubble  = 1'b0;
    pcSrcBranch = 1'b0;
    brTimeout   = 1'b0;
    if (!rst) begin
      case (state)
        ST_IDLE: begin
          if (loadUse) begin
            PChold     = 1'b1;
            IFIDhold   = 1'b1;
            IDEXbubble = 1'b1;
          end else if (beqID || bneID) begin
            PChold    = 1'b1;
            IFIDflush = 1'b1;
            state_n   = ST_BR_WAIT;
            cnt_n     = '0;
          end
        end
        ST_BR_WAIT: begin
          if (branchResolve) begin
            state_n = ST_IDLE;
            if (branchTaken) begin
              pcSrcBranch = 1'b1;
              IFIDflush   = 1'b1;
            end
          end else begin
            PChold     = 1'b1;
            IFIDhold   = 1'b1;
            IDEXbubble = 1'b1;
            cnt_n      = cnt + CW'(1);
            if (cnt == CNT_LAST) begin
              brTimeout = 1'b1;
              state_n   = ST_IDLE;
            end
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic ld_inc, br_inc;

  // Load stalls only arise in IDLE; every other PChold comes from the branch path.
  always_comb begin
    ld_inc = !rst && (state == ST_IDLE) && loadUse;
    br_inc = PChold && !ld_inc;
  end

  // Saturating stall counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      loadStallCnt   <= '0;
      branchStallCnt <= '0;
    end else begin
      if (ld_inc && !(&loadStallCnt))   loadStallCnt   <= loadStallCnt + CNT_W'(1);
      if (br_inc && !(&branchStallCnt)) branchStallCnt <= branchStallCnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_branch_hazard_sequencer.sv
// Self-checking bench for branch_hazard_sequencer (REG_AW=5, BR_MAX_WAIT=4).
// Expected outputs packed as {PChold, IFIDhold, IFIDflush, IDEXbubble, pcSrcBranch, brTimeout}.
module tb_branch_hazard_sequencer;

  localparam int unsigned AW = 5;

  logic clk = 1'b0;
  logic rst, beqID, bneID, branchResolve, branchTaken, memReadEX;
  logic [AW-1:0] rtEX, rsID, rtID;
  logic PChold, IFIDhold, IFIDflush, IDEXbubble, pcSrcBranch, brTimeout;
`ifdef HAZARD_PERF_EN
  logic [15:0] loadStallCnt, branchStallCnt;
`endif

  always #5 clk = ~clk;

  branch_hazard_sequencer #(.REG_AW(AW), .BR_MAX_WAIT(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .beqID(beqID), .bneID(bneID),
    .branchResolve(branchResolve), .branchTaken(branchTaken),
    .memReadEX(memReadEX), .rtEX(rtEX), .rsID(rsID), .rtID(rtID),
    .PChold(PChold), .IFIDhold(IFIDhold), .IFIDflush(IFIDflush),
    .IDEXbubble(IDEXbubble), .pcSrcBranch(pcSrcBranch),
`ifdef HAZARD_PERF_EN
    .loadStallCnt(loadStallCnt), .branchStallCnt(branchStallCnt),
`endif
    .brTimeout(brTimeout)
  );

  typedef struct {
    string        name;
    logic         rst, beq, bne, res, tkn, mr;
    logic [AW-1:0] rte, rs, rt;
    logic [5:0]   exp;
  } vec_t;

  localparam logic [5:0] NONE  = 6'b000000;
  localparam logic [5:0] LSTAL = 6'b110100; // PChold, IFIDhold, IDEXbubble
  localparam logic [5:0] DET   = 6'b101000; // PChold, IFIDflush
  localparam logic [5:0] TAKEN = 6'b001010; // IFIDflush, pcSrcBranch
  localparam logic [5:0] TOUT  = 6'b110101; // holds + brTimeout

  vec_t        vecs[$];
  logic [5:0]  exp_q[$];
  string       name_q[$];
  int          nvec = 0;
  int          nfail = 0;

  function automatic vec_t mk(string n, logic r, logic bq, logic bn, logic rs_, logic tk,
                              logic m, int te, int s, int t, logic [5:0] e);
    vec_t v;
    v.name = n; v.rst = r; v.beq = bq; v.bne = bn; v.res = rs_; v.tkn = tk; v.mr = m;
    v.rte = AW'(te); v.rs = AW'(s); v.rt = AW'(t); v.exp = e;
    return v;
  endfunction

  // Drive one cycle of stimulus, queue its expectation, check at the falling edge.
  task automatic apply(input vec_t v);
    logic [5:0] act, e;
    string      n;
    rst = v.rst; beqID = v.beq; bneID = v.bne; branchResolve = v.res;
    branchTaken = v.tkn; memReadEX = v.mr; rtEX = v.rte; rsID = v.rs; rtID = v.rt;
    exp_q.push_back(v.exp);
    name_q.push_back(v.name);
    @(negedge clk);
    act = {PChold, IFIDhold, IFIDflush, IDEXbubble, pcSrcBranch, brTimeout};
    e = exp_q.pop_front();
    n = name_q.pop_front();
    nvec++;
    if (act !== e) begin
      nfail++;
      $display("FAIL %s: got %b expected %b", n, act, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string n, input int act, input int e);
    nvec++;
    if (act != e) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", n, act, e);
    end
  endtask

  initial begin
    rst = 1'b1; beqID = 1'b0; bneID = 1'b0; branchResolve = 1'b0; branchTaken = 1'b0;
    memReadEX = 1'b0; rtEX = '0; rsID = '0; rtID = '0;
    @(posedge clk); #1;

    // Reset with a branch pending, then load-use patterns.
    vecs.push_back(mk("rst0",        1,1,0,0,0,0, 0,0,0, NONE));
    vecs.push_back(mk("rst1",        1,1,0,0,0,0, 0,0,0, NONE));
    vecs.push_back(mk("idle",        0,0,0,0,0,0, 0,0,0, NONE));
    vecs.push_back(mk("lu_rs",       0,0,0,0,0,1, 5,5,0, LSTAL));
    vecs.push_back(mk("lu_r0",       0,0,0,0,0,1, 0,0,0, NONE));
    vecs.push_back(mk("lu_rt",       0,0,0,0,0,1, 7,3,7, LSTAL));
    vecs.push_back(mk("lu_nomem",    0,0,0,0,0,0, 5,5,5, NONE));
    vecs.push_back(mk("lu_nomatch",  0,0,0,0,0,1, 6,5,4, NONE));
    // Taken branch resolved on the second wait cycle.
    vecs.push_back(mk("beq_det",     0,1,0,0,0,0, 0,0,0, DET));
    vecs.push_back(mk("beq_wait",    0,0,0,0,0,0, 0,0,0, LSTAL));
    vecs.push_back(mk("beq_taken",   0,0,0,1,1,0, 0,0,0, TAKEN));
    vecs.push_back(mk("post_taken",  0,0,0,0,0,0, 0,0,0, NONE));
    // Not-taken bne resolved on the first wait cycle.
    vecs.push_back(mk("bne_det",     0,0,1,0,0,0, 0,0,0, DET));
    vecs.push_back(mk("bne_nt",      0,0,0,1,0,0, 0,0,0, NONE));
    vecs.push_back(mk("idle_res",    0,0,0,1,1,0, 0,0,0, NONE));
    // Timeout; ID inputs and unqualified branchTaken ignored while waiting.
    vecs.push_back(mk("to_det",      0,1,0,0,0,0, 0,0,0, DET));
    vecs.push_back(mk("to_w0_beq",   0,1,0,0,0,0, 0,0,0, LSTAL));
    vecs.push_back(mk("to_w1_lu",    0,0,0,0,0,1, 5,5,0, LSTAL));
    vecs.push_back(mk("to_w2_tkn",   0,0,0,0,1,0, 0,0,0, LSTAL));
    vecs.push_back(mk("to_w3",       0,0,0,0,0,0, 0,0,0, TOUT));
    vecs.push_back(mk("to_after",    0,0,0,0,0,0, 0,0,0, NONE));
    // Load stall takes priority over a branch; branch proceeds next cycle; reset aborts it.
    vecs.push_back(mk("pri_lu",      0,1,0,0,0,1, 5,5,0, LSTAL));
    vecs.push_back(mk("pri_det",     0,1,0,0,0,0, 0,0,0, DET));
    vecs.push_back(mk("pri_wait",    0,0,0,0,0,0, 0,0,0, LSTAL));
    vecs.push_back(mk("mid_rst",     1,0,0,1,1,0, 0,0,0, NONE));
    vecs.push_back(mk("rst_idle",    0,0,0,1,1,0, 0,0,0, NONE));

    for (int unsigned i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Resolve arriving on the final permitted wait cycle beats the timeout.
    apply(mk("late_det", 0,0,1,0,0,0, 0,0,0, DET));
    for (int unsigned i = 0; i < 3; i++) apply(mk("late_wait", 0,0,0,0,0,0, 0,0,0, LSTAL));
    apply(mk("late_res", 0,0,0,1,1,0, 0,0,0, TAKEN));
    apply(mk("late_idle", 0,0,0,0,0,0, 0,0,0, NONE));

    // Back-to-back branches: counter restarts for the second one.
    apply(mk("b2b_det0", 0,1,0,0,0,0, 0,0,0, DET));
    apply(mk("b2b_res0", 0,0,0,1,0,0, 0,0,0, NONE));
    apply(mk("b2b_det1", 0,1,0,0,0,0, 0,0,0, DET));
    for (int unsigned i = 0; i < 3; i++) apply(mk("b2b_wait", 0,0,0,0,0,0, 0,0,0, LSTAL));
    apply(mk("b2b_to", 0,0,0,0,0,0, 0,0,0, TOUT));

`ifdef HAZARD_PERF_EN
    apply(mk("perf_rst", 1,0,0,0,0,0, 0,0,0, NONE));
    check_cnt("perf_rst_ld", int'(loadStallCnt), 0);
    check_cnt("perf_rst_br", int'(branchStallCnt), 0);
    apply(mk("perf_det",   0,1,0,0,0,0, 0,0,0, DET));
    apply(mk("perf_wait",  0,0,0,0,0,0, 0,0,0, LSTAL));
    apply(mk("perf_taken", 0,0,0,1,1,0, 0,0,0, TAKEN));
    apply(mk("perf_lu",    0,0,0,0,0,1, 5,5,0, LSTAL));
    apply(mk("perf_nolu",  0,0,0,0,0,1, 0,0,0, NONE));
    check_cnt("perf_br", int'(branchStallCnt), 2);
    check_cnt("perf_ld", int'(loadStallCnt), 1);
`endif

    check_cnt("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
